// File: rtl/freq_gate_sequencer.sv
// Measurement sequencer for the frequency meter: clear -> gate -> settle -> latch -> eval,
// gating synchronized input edges into the BCD counter with optional auto-ranging.
module freq_gate_sequencer #(
    parameter logic [23:0] GATE0_US = 24'd10_000,
    parameter logic [23:0] GATE1_US = 24'd100_000,
    parameter logic [23:0] GATE2_US = 24'd1_000_000,
    parameter logic [23:0] GATE3_US = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       auto_rng,
    input  logic [1:0] man_rng,
    input  logic       tick_1us,
    input  logic       sig_edge,
    input  logic       cnt_carry,
    input  logic       cnt_msd_zero,
    output logic       cnt_enable,
    output logic       cnt_clear,
    output logic       cnt_latch,
    output logic       gate_active,
    output logic [1:0] range,
    output logic [2:0] dp_pos,
    output logic       overrange,
    output logic       meas_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_GATE   = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_LATCH  = 3'd4;
    localparam logic [2:0] S_EVAL   = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [23:0] timer_q, timer_d;
    logic        ovf_q, ovf_d;
    logic [1:0]  active_q, active_d;
    logic [1:0]  range_q, range_d;
    logic [2:0]  dp_q, dp_d;
    logic        ovr_q, ovr_d;
    logic [23:0] gate_len;

    always_comb begin
        case (active_q)
            2'd0:    gate_len = GATE0_US;
            2'd1:    gate_len = GATE1_US;
            2'd2:    gate_len = GATE2_US;
            default: gate_len = GATE3_US;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        ovf_d    = ovf_q;
        active_d = active_q;
        range_d  = range_q;
        dp_d     = dp_q;
        ovr_d    = ovr_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                timer_d = '0;
                ovf_d   = 1'b0;
                if (!auto_rng) active_d = man_rng;
                state_d = S_GATE;
            end
            S_GATE: begin
                if (cnt_carry) ovf_d = 1'b1;
                if (tick_1us) begin
                    if (timer_q == gate_len - 24'd1) state_d = S_SETTLE;
                    else                             timer_d = timer_q + 24'd1;
                end
            end
            S_SETTLE: begin
                // Carry from the last gated edge may arrive one clock late.
                if (cnt_carry) ovf_d = 1'b1;
                state_d = S_LATCH;
            end
            S_LATCH: begin
                range_d = active_q;
                dp_d    = {1'b0, active_q} + 3'd1;
                ovr_d   = ovf_q;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                if (auto_rng) begin
                    if (ovf_q) begin
                        if (active_q != 2'd0) active_d = active_q - 2'd1;
                    end else if (cnt_msd_zero && active_q != 2'd3) begin
                        active_d = active_q + 2'd1;
                    end
                end
                state_d = S_CLEAR;
            end
            default: state_d = S_IDLE;
        endcase
        if (!run) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            ovf_q    <= 1'b0;
            active_q <= 2'd2;
            range_q  <= 2'd2;
            dp_q     <= 3'd3;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            ovf_q    <= ovf_d;
            active_q <= active_d;
            range_q  <= range_d;
            dp_q     <= dp_d;
            ovr_q    <= ovr_d;
        end
    end

    // Edge gating is combinational so an edge in the final gate clock is still counted.
    assign cnt_enable  = sig_edge && (state_q == S_GATE);
    assign cnt_clear   = (state_q == S_CLEAR);
    assign gate_active = (state_q == S_GATE);
    assign cnt_latch   = (state_q == S_LATCH);
    assign meas_done   = (state_q == S_LATCH);
    assign range       = range_q;
    assign dp_pos      = dp_q;
    assign overrange   = ovr_q;

endmodule

// File: tb/tb_freq_gate_sequencer.sv
// Bench for freq_gate_sequencer: table of directed measurements, abort/reset sequences,
// then randomized ticks/edges/carries checked against a per-measurement reference model.
module tb_freq_gate_sequencer;

    localparam logic [23:0] G0 = 24'd4;
    localparam logic [23:0] G1 = 24'd8;
    localparam logic [23:0] G2 = 24'd20;
    localparam logic [23:0] G3 = 24'd30;
    localparam int NONE = -99;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       auto_rng = 1'b0;
    logic [1:0] man_rng = 2'd2;
    logic       tick_1us = 1'b0;
    logic       sig_edge = 1'b0;
    logic       cnt_carry = 1'b0;
    logic       cnt_msd_zero = 1'b0;
    logic       cnt_enable, cnt_clear, cnt_latch, gate_active, overrange, meas_done;
    logic [1:0] range;
    logic [2:0] dp_pos;

    int n_chk = 0;
    int n_fail = 0;

    freq_gate_sequencer #(
        .GATE0_US(G0), .GATE1_US(G1), .GATE2_US(G2), .GATE3_US(G3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .auto_rng(auto_rng), .man_rng(man_rng),
        .tick_1us(tick_1us), .sig_edge(sig_edge), .cnt_carry(cnt_carry),
        .cnt_msd_zero(cnt_msd_zero), .cnt_enable(cnt_enable), .cnt_clear(cnt_clear),
        .cnt_latch(cnt_latch), .gate_active(gate_active), .range(range), .dp_pos(dp_pos),
        .overrange(overrange), .meas_done(meas_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       a;
        logic [1:0] m;
        logic [1:0] m2;
        int         carry_at;
        logic       msd;
        int         edge_mod;
        logic [1:0] exp_rng;
        int         exp_glen;
        int         exp_enab;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int gate_n(input logic [1:0] r);
        case (r)
            2'd0:    return int'(G0);
            2'd1:    return int'(G1);
            2'd2:    return int'(G2);
            default: return int'(G3);
        endcase
    endfunction

    // One full measurement with tick every clock; c counts clocks from the CLEAR clock.
    task automatic do_meas(input vec_t v, output int glen, output int enab, output int stray,
                           output int lat_c, output int latches, output int dones,
                           output int wait_n, output logic [1:0] rng, output logic [2:0] dp,
                           output logic ovr);
        int  c, cn;
        bit  started, done;
        glen = 0; enab = 0; stray = 0; latches = 0; dones = 0; wait_n = 0;
        lat_c = -10; c = -1; started = 0; done = 0;
        rng = '0; dp = '0; ovr = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(posedge clk); #1;
            cn           = started ? c + 1 : -1;
            auto_rng     = v.a;
            tick_1us     = 1'b1;
            cnt_msd_zero = v.msd;
            man_rng      = (cn >= 2) ? v.m2 : v.m;
            sig_edge     = (v.edge_mod > 0 && cn > 0 && (cn % v.edge_mod) == 0);
            cnt_carry    = (cn == v.carry_at);
            @(negedge clk);
            if (!started) begin
                if (cnt_clear) begin started = 1; c = 0; end
                else wait_n++;
            end else begin
                c = cn;
            end
            if (started) begin
                if (gate_active) begin glen++; enab += int'(cnt_enable); end
                else stray += int'(cnt_enable);
                if (cnt_latch) begin latches++; lat_c = c; dones += int'(meas_done); end
                if (c == lat_c + 1) begin
                    rng = range; dp = dp_pos; ovr = overrange; done = 1;
                end
            end
        end
        if (!done) chk("meas_timeout", 0, 1);
        sig_edge = 1'b0; cnt_carry = 1'b0;
    endtask

    initial begin
        int glen, enab, stray, lat_c, latches, dones, wait_n, cyc;
        logic [1:0] rng;
        logic [2:0] dp;
        logic ovr;
        int model_act, since, ticks, edges, enab_r, stray_r, bad_latch, meas_cnt;
        logic cs;

        //            a  m  m2  carry msd edge | rng glen enab ovr
        vecs[0]  = '{1'b0, 2'd2, 2'd2, NONE, 1'b0, 10, 2'd2, 20,  2, 1'b0};
        vecs[1]  = '{1'b0, 2'd0, 2'd0, 5,    1'b1, 2,  2'd0, 4,   2, 1'b1};
        vecs[2]  = '{1'b0, 2'd3, 2'd3, 5,    1'b0, 3,  2'd3, 30, 10, 1'b1};
        vecs[3]  = '{1'b1, 2'd0, 2'd0, NONE, 1'b1, 1,  2'd3, 30, 30, 1'b0};
        vecs[4]  = '{1'b1, 2'd0, 2'd0, 7,    1'b1, 0,  2'd3, 30,  0, 1'b1};
        vecs[5]  = '{1'b1, 2'd0, 2'd0, 3,    1'b0, 0,  2'd2, 20,  0, 1'b1};
        vecs[6]  = '{1'b1, 2'd0, 2'd0, NONE, 1'b1, 4,  2'd1, 8,   2, 1'b0};
        vecs[7]  = '{1'b1, 2'd0, 2'd0, NONE, 1'b0, 0,  2'd2, 20,  0, 1'b0};
        vecs[8]  = '{1'b1, 2'd0, 2'd0, 2,    1'b1, 0,  2'd2, 20,  0, 1'b1};
        vecs[9]  = '{1'b1, 2'd0, 2'd0, 1,    1'b0, 0,  2'd1, 8,   0, 1'b1};
        vecs[10] = '{1'b1, 2'd0, 2'd0, 1,    1'b0, 0,  2'd0, 4,   0, 1'b1};
        vecs[11] = '{1'b1, 2'd0, 2'd0, NONE, 1'b1, 0,  2'd0, 4,   0, 1'b0};
        vecs[12] = '{1'b0, 2'd0, 2'd3, NONE, 1'b0, 0,  2'd0, 4,   0, 1'b0};
        vecs[13] = '{1'b0, 2'd3, 2'd3, NONE, 1'b0, 5,  2'd3, 30,  6, 1'b0};

        // Reset state
        #12;
        chk("rst_gate_active", int'(gate_active), 0);
        chk("rst_strobes", int'({cnt_clear, cnt_latch, meas_done, cnt_enable}), 0);
        chk("rst_range", int'(range), 2);
        chk("rst_dp_pos", int'(dp_pos), 3);
        chk("rst_overrange", int'(overrange), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_no_run", int'(gate_active | cnt_clear), 0);
        run = 1'b1;

        for (int i = 0; i < 14; i++) begin
            do_meas(vecs[i], glen, enab, stray, lat_c, latches, dones, wait_n, rng, dp, ovr);
            $display("meas %0d: range=%0d dp=%0d ovr=%0d gate=%0d enables=%0d", i, rng, dp, ovr, glen, enab);
            chk($sformatf("v%0d_gate_len", i), glen, vecs[i].exp_glen);
            chk($sformatf("v%0d_enables", i), enab, vecs[i].exp_enab);
            chk($sformatf("v%0d_stray_enable", i), stray, 0);
            chk($sformatf("v%0d_range", i), int'(rng), int'(vecs[i].exp_rng));
            chk($sformatf("v%0d_dp_pos", i), int'(dp), int'(vecs[i].exp_rng) + 1);
            chk($sformatf("v%0d_overrange", i), int'(ovr), int'(vecs[i].exp_ovr));
            chk($sformatf("v%0d_latch_cnt", i), latches, 1);
            chk($sformatf("v%0d_meas_done", i), dones, 1);
            chk($sformatf("v%0d_latch_pos", i), lat_c, vecs[i].exp_glen + 2);
            if (i > 0) chk($sformatf("v%0d_dead_time", i), wait_n, 0);
        end

        // Abort mid-gate: IDLE on the next clock, no latch, display held
        cyc = 0;
        while (!gate_active && cyc < 100) begin @(negedge clk); cyc++; end
        chk("abort_gate_seen", int'(gate_active), 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        run = 1'b0;
        @(posedge clk); #1;
        chk("abort_next_clk", int'(gate_active), 0);
        latches = 0; glen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            latches += int'(cnt_latch | meas_done);
            glen += int'(gate_active | cnt_clear);
        end
        $display("abort: latches=%0d activity=%0d range=%0d ovr=%0d", latches, glen, range, overrange);
        chk("abort_no_latch", latches, 0);
        chk("abort_idle", glen, 0);
        chk("abort_range_held", int'(range), 3);
        chk("abort_ovr_held", int'(overrange), 0);

        // Async reset mid-gate
        run = 1'b1;
        cyc = 0;
        while (!gate_active && cyc < 100) begin @(negedge clk); cyc++; end
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        sig_edge = 1'b1;
        rst_n = 1'b0;
        #1;
        $display("async reset: gate=%0d range=%0d dp=%0d", gate_active, range, dp_pos);
        chk("arst_gate_active", int'(gate_active), 0);
        chk("arst_enable", int'(cnt_enable), 0);
        chk("arst_range", int'(range), 2);
        chk("arst_dp_pos", int'(dp_pos), 3);
        sig_edge = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Randomized phase with a per-measurement reference model
        model_act = 2; since = 99; ticks = 0; edges = 0; enab_r = 0; cs = 1'b0;
        stray_r = 0; bad_latch = 0; meas_cnt = 0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            tick_1us     = ($urandom_range(0, 1) == 0);
            sig_edge     = ($urandom_range(0, 2) == 0);
            cnt_carry    = ($urandom_range(0, 29) == 0);
            cnt_msd_zero = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 63) == 0) auto_rng = ~auto_rng;
            if ($urandom_range(0, 31) == 0) man_rng = 2'($urandom_range(0, 3));
            @(negedge clk);
            if (cnt_clear) begin
                if (!auto_rng) model_act = int'(man_rng);
                ticks = 0; edges = 0; enab_r = 0; cs = 1'b0;
            end
            if (gate_active) begin
                ticks += int'(tick_1us);
                edges += int'(sig_edge);
                enab_r += int'(cnt_enable);
                cs |= cnt_carry;
                since = 0;
            end else begin
                stray_r += int'(cnt_enable);
                if (since < 99) since++;
                if (since == 1) cs |= cnt_carry;
                if (since == 2) chk("rnd_latch", int'(cnt_latch & meas_done), 1);
                else bad_latch += int'(cnt_latch);
                if (since == 3) begin
                    meas_cnt++;
                    $display("rnd meas %0d: range=%0d ovr=%0d ticks=%0d enables=%0d", meas_cnt, range, overrange, ticks, enab_r);
                    chk("rnd_range", int'(range), model_act);
                    chk("rnd_dp_pos", int'(dp_pos), model_act + 1);
                    chk("rnd_overrange", int'(overrange), int'(cs));
                    chk("rnd_ticks", ticks, gate_n(2'(model_act)));
                    chk("rnd_enables", enab_r, edges);
                    if (auto_rng) begin
                        if (cs && model_act > 0) model_act--;
                        else if (!cs && cnt_msd_zero && model_act < 3) model_act++;
                    end
                end
                if (since == 4) chk("rnd_clear", int'(cnt_clear), 1);
            end
        end
        chk("rnd_stray_enable", stray_r, 0);
        chk("rnd_bad_latch", bad_latch, 0);
        chk("rnd_meas_count_ok", int'(meas_cnt >= 10), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
